id_ex_stage: RTL and testbench

Execute-stage front end of the pipelined RISC-V core. Holds the ID/EX pipeline register, resolves operand forwarding from the EX/MEM and MEM/WB stages, and drives `SrcA`, `SrcB` and `Operation` straight into the ALU. Also detects load-use hazards, raises a stall toward IF/ID, and inserts a bubble into EX.

---
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register, operand forwarding and hazard stall feeding the ALU.
// Define FORWARDING_EN to build the EX/MEM and MEM/WB bypass muxes; otherwise dependent instructions stall.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alu_src_imm,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      id_reg_write,
  input  logic                      flush,
  input  logic                      hold,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      stall,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      ex_valid,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd
);
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [OPCODE_LENGTH-1:0]  alu_op;
    logic                      alu_src_imm;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
  } ex_t;
  ex_t ex_q, ex_d, id_w;
  logic hz1, hz2;
  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
  assign id_w = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                  alu_op: id_alu_op, alu_src_imm: id_alu_src_imm, mem_read: id_mem_read,
                  mem_write: id_mem_write, reg_write: id_reg_write};
`ifdef FORWARDING_EN
  assign hz1 = id_uses_rs1 && id_rs1 == ex_q.rd;
  assign hz2 = id_uses_rs2 && id_rs2 == ex_q.rd;
  assign stall = !hold && id_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != '0 && (hz1 || hz2);
  assign rs1_fwd = (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs1) ? exmem_result :
                   (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs1) ? memwb_result :
                   ex_q.rs1_data;
  assign rs2_fwd = (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs2) ? exmem_result :
                   (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs2) ? memwb_result :
                   ex_q.rs2_data;
`else
  // Without bypassing, wait until the producer has left EX/MEM; the register file covers WB.
  assign hz1 = id_uses_rs1 && id_rs1 != '0 &&
               ((ex_q.valid && ex_q.reg_write && ex_q.rd == id_rs1) || (exmem_reg_write && exmem_rd == id_rs1));
  assign hz2 = id_uses_rs2 && id_rs2 != '0 &&
               ((ex_q.valid && ex_q.reg_write && ex_q.rd == id_rs2) || (exmem_reg_write && exmem_rd == id_rs2));
  assign stall = !hold && id_valid && (hz1 || hz2);
  assign rs1_fwd = ex_q.rs1_data;
  assign rs2_fwd = ex_q.rs2_data;
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, memwb_rd, memwb_reg_write, memwb_result, ex_q.rs1, ex_q.rs2};
`endif
  assign ex_d = flush ? '0 : hold ? ex_q : stall ? '0 : id_w;
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else ex_q <= ex_d;
  end
  assign SrcA          = rs1_fwd;
  assign SrcB          = ex_q.alu_src_imm ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign Operation     = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_rd         = ex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, load-use stall, flush and hold.
module tb_id_ex_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_alu_src_imm, id_mem_read, id_mem_write, id_reg_write;
  logic [4:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, ex_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result, SrcA, SrcB, ex_store_data;
  logic [3:0] id_alu_op, Operation;
  logic flush, hold, exmem_reg_write, memwb_reg_write;
  logic stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  int tests = 0, fails = 0;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .flush(flush), .hold(hold), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .stall(stall), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] op, input logic si,
                        input logic mr, input logic mw, input logic rw);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op; id_alu_src_imm = si;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task automatic set_fwd(input logic [4:0] er, input logic ew, input logic [31:0] ed,
                         input logic [4:0] mr, input logic mw, input logic [31:0] md);
    exmem_rd = er; exmem_reg_write = ew; exmem_result = ed;
    memwb_rd = mr; memwb_reg_write = mw; memwb_result = md;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    flush = 0; hold = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1; flush = 0; hold = 0;
    r = $urandom;
    set_id(1, r[4:0], r[9:5], r[14:10], 1, 1, $urandom, $urandom, $urandom, r[18:15], r[19], r[20], r[21], 1);
    set_fwd(r[26:22], 1, $urandom, r[31:27], 1, $urandom);
    repeat (2) @(posedge clk);
    #1; reset = 0; idle(); #1;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", ex_valid); end
    tests++; if ({ex_mem_read, ex_mem_write, ex_reg_write} !== 3'b000) begin fails++; $display("FAIL rst_ctrl: got %b expected 000", {ex_mem_read, ex_mem_write, ex_reg_write}); end
    tests++; if (ex_rd !== 5'd0) begin fails++; $display("FAIL rst_rd: got %0d expected 0", ex_rd); end
    tests++; if (Operation !== 4'd0) begin fails++; $display("FAIL rst_op: got %h expected 0", Operation); end
    tests++; if ({SrcA, SrcB, ex_store_data} !== 96'd0) begin fails++; $display("FAIL rst_data: got %h %h %h expected 0", SrcA, SrcB, ex_store_data); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b expected 0", stall); end
  endtask

  task automatic test_back_to_back();
    idle(); tick();
    set_id(1, 2, 3, 5, 1, 1, 7, 9, 0, 4'h2, 0, 0, 0, 1);
    tick();
    set_id(1, 5, 1, 6, 1, 1, 32'hDEAD, 3, 0, 4'h2, 0, 0, 0, 1); #1;
    tests++; if (stall !== !FWD) begin fails++; $display("FAIL b2b_stall1: got %b expected %b", stall, !FWD); end
    if (!FWD) begin
      tick(); set_fwd(5, 1, 32'h10, 0, 0, 0); #1;
      tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL b2b_bubble: got %b expected 0", ex_valid); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_stall2: got %b expected 1", stall); end
      tick(); set_fwd(0, 0, 0, 5, 1, 32'h10);
      set_id(1, 5, 1, 6, 1, 1, 32'h10, 3, 0, 4'h2, 0, 0, 0, 1); #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall3: got %b expected 0", stall); end
    end
    tick(); set_fwd(5, 1, 32'h10, 0, 0, 0);
    if (!FWD) set_fwd(0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (SrcA !== 32'h10) begin fails++; $display("FAIL b2b_srca: got %h expected 10", SrcA); end
    tests++; if (SrcB !== 32'h3) begin fails++; $display("FAIL b2b_srcb: got %h expected 3", SrcB); end
    tests++; if ({ex_valid, ex_rd, Operation} !== {1'b1, 5'd6, 4'h2}) begin fails++; $display("FAIL b2b_ctrl: got %b %0d %h expected 1 6 2", ex_valid, ex_rd, Operation); end
    if (FWD) begin
      exmem_reg_write = 0; #1;
      tests++; if (SrcA !== 32'hDEAD) begin fails++; $display("FAIL b2b_comb: got %h expected dead", SrcA); end
    end
  endtask

  task automatic test_double_forward();
    idle(); tick();
    set_id(1, 7, 7, 10, 1, 1, 32'h11, 32'h33, 32'h123, 4'h5, 1, 0, 0, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(7, 1, 32'hAA, 7, 1, 32'h55); #1;
    tests++; if (SrcA !== (FWD ? 32'hAA : 32'h11)) begin fails++; $display("FAIL dfwd_srca: got %h expected %h", SrcA, FWD ? 32'hAA : 32'h11); end
    tests++; if (SrcB !== 32'h123) begin fails++; $display("FAIL dfwd_imm: got %h expected 123", SrcB); end
    tests++; if (ex_store_data !== (FWD ? 32'hAA : 32'h33)) begin fails++; $display("FAIL dfwd_store: got %h expected %h", ex_store_data, FWD ? 32'hAA : 32'h33); end
    exmem_reg_write = 0; #1;
    tests++; if (SrcA !== (FWD ? 32'h55 : 32'h11)) begin fails++; $display("FAIL dfwd_memwb: got %h expected %h", SrcA, FWD ? 32'h55 : 32'h11); end
  endtask

  task automatic test_load_use();
    idle(); tick();
    set_id(1, 2, 0, 8, 1, 0, 32'h100, 0, 4, 4'h0, 1, 1, 0, 1);
    tick();
    set_id(1, 8, 8, 9, 1, 1, 32'hBAD, 32'hBAD, 0, 4'h1, 0, 0, 0, 1); #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b expected 1", stall); end
    tick(); set_fwd(8, 1, 32'h104, 0, 0, 0); #1;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble: got %b expected 0", ex_valid); end
    tests++; if (stall !== !FWD) begin fails++; $display("FAIL lu_stall_len: got %b expected %b", stall, !FWD); end
    if (!FWD) begin
      tick(); set_fwd(0, 0, 0, 8, 1, 32'h77);
      set_id(1, 8, 8, 9, 1, 1, 32'h77, 32'h77, 0, 4'h1, 0, 0, 0, 1); #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_end: got %b expected 0", stall); end
    end
    tick(); set_fwd(0, 0, 0, 8, 1, 32'h77);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if ({SrcA, SrcB} !== {32'h77, 32'h77}) begin fails++; $display("FAIL lu_fwd: got %h %h expected 77 77", SrcA, SrcB); end
    tests++; if ({ex_valid, ex_rd} !== {1'b1, 5'd9}) begin fails++; $display("FAIL lu_capture: got %b %0d expected 1 9", ex_valid, ex_rd); end
    idle(); tick();
    set_id(1, 2, 0, 0, 1, 0, 32'h100, 0, 4, 4'h0, 1, 1, 0, 1);
    tick();
    set_id(1, 0, 0, 3, 1, 1, 32'h22, 32'h22, 0, 4'h1, 0, 0, 0, 1);
    set_fwd(0, 1, 32'hAA, 0, 1, 32'h55); #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall: got %b expected 0", stall); end
    tick(); #1;
    tests++; if (SrcA !== 32'h22) begin fails++; $display("FAIL x0_fwd: got %h expected 22", SrcA); end
  endtask

  task automatic test_flush();
    idle(); tick();
    set_id(1, 2, 0, 8, 1, 0, 32'h100, 0, 4, 4'h0, 1, 1, 0, 1);
    tick();
    set_id(1, 8, 8, 9, 1, 1, 32'hBAD, 32'hBAD, 0, 4'h1, 0, 0, 0, 1);
    flush = 1; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fl_stall_in: got %b expected 1", stall); end
    tick(); flush = 0; set_fwd(8, 1, 32'h104, 0, 0, 0); #1;
    tests++; if ({ex_valid, ex_mem_read, ex_rd} !== 7'd0) begin fails++; $display("FAIL fl_bubble: got %b %b %0d expected 0 0 0", ex_valid, ex_mem_read, ex_rd); end
    tests++; if (stall !== !FWD) begin fails++; $display("FAIL fl_stall_out: got %b expected %b", stall, !FWD); end
    idle(); tick();
    set_id(1, 1, 2, 12, 1, 1, 1, 2, 0, 4'h3, 0, 0, 0, 1);
    tick();
    set_id(1, 3, 4, 13, 1, 1, 3, 4, 0, 4'h4, 0, 0, 0, 1);
    hold = 1; flush = 1;
    tick(); hold = 0; flush = 0; #1;
    tests++; if ({ex_valid, ex_rd} !== 6'd0) begin fails++; $display("FAIL fl_hold: got %b %0d expected 0 0", ex_valid, ex_rd); end
  endtask

  task automatic test_hold_and_reset();
    idle(); tick();
    set_id(1, 3, 4, 11, 1, 1, 5, 6, 0, 4'h3, 0, 1, 0, 1);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 11, 5'(i + 1), 5'(20 + i), 1, 1, i, i, i, 4'(i), 0, 0, 0, 1); #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hold_stall%0d: got %b expected 0", i, stall); end
      tick();
      tests++; if ({ex_valid, ex_rd, Operation, SrcA, SrcB} !== {1'b1, 5'd11, 4'h3, 32'd5, 32'd6}) begin
        fails++; $display("FAIL hold_keep%0d: got %b %0d %h %h %h expected 1 11 3 5 6", i, ex_valid, ex_rd, Operation, SrcA, SrcB);
      end
    end
    hold = 0; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hold_release: got %b expected 1", stall); end
    reset = 1;
    tick(); reset = 0; #1;
    tests++; if ({ex_valid, stall} !== 2'b00) begin fails++; $display("FAIL rst_mid_stall: got %b %b expected 0 0", ex_valid, stall); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_double_forward();
    test_load_use();
    test_flush();
    test_hold_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
